// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, frame constants and frame builder for the PS/2 keyboard transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_tx_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;

    // Bit 0 goes on the wire first: start(0), data LSB-first, odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: byte FIFO feeding the PS/2 frame engine; one extra pointer bit separates full from empty.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 frame transmitter (keyboard end of the link).
// Define PS2_TX_FIFO_EN to put a DEPTH-entry byte FIFO in front of the frame engine.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int GAP     = 16,
    parameter int DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       tx_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP + 1);

    if (CLK_DIV < 4 || GAP < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("ps2_kbd_tx: need CLK_DIV >= 4, GAP >= 1, DEPTH a power of two >= 2");
    end

    ps2_tx_state_t             state;
    ps2_tx_state_t             state_nx;
    logic [DIV_W-1:0]          div_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic [3:0]                bit_idx;
    logic [PS2_FRAME_BITS-1:0] shreg;
    logic [PS2_FRAME_BITS-1:0] frame_ld;
    logic                      src_valid;
    logic                      src_take;
    logic [7:0]                src_data;
    logic                      div_last;
    logic                      gap_last;

    assign src_take = (state == ST_IDLE) && src_valid;

`ifdef PS2_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    ps2_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .pop     (src_take),
        .wr_data (in_data),
        .rd_data (src_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready  = ~fifo_full;
    assign src_valid = ~fifo_empty;
`else
    assign in_ready  = (state == ST_IDLE);
    assign src_valid = in_valid;
    assign src_data  = in_data;
`endif

    assign frame_ld = ps2_frame(src_data);
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign gap_last = (gap_cnt == GAP_W'(GAP - 1));
    assign busy     = (state != ST_IDLE);

    always_comb begin
        // NOTE: default first so every path assigns state_nx; a missing branch would infer a latch.
        state_nx = state;
        unique case (state)
            ST_IDLE: if (src_valid) state_nx = ST_HIGH;
            ST_HIGH: if (div_last)  state_nx = ST_LOW;
            ST_LOW:  if (div_last)  state_nx = (bit_idx == 4'(PS2_FRAME_BITS - 1)) ? ST_GAP : ST_HIGH;
            ST_GAP:  if (gap_last)  state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_nx;
            ps2_clk <= (state_nx != ST_LOW);
            tx_done <= (state == ST_LOW) && (state_nx == ST_GAP);

            if (state_nx != state || (state != ST_HIGH && state != ST_LOW)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state == ST_GAP && state_nx == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            // Data only moves on entry to HIGH, so it is stable across every falling edge.
            if (src_take) begin
                shreg    <= frame_ld;
                bit_idx  <= '0;
                ps2_data <= frame_ld[0];
            end else if (state == ST_LOW && state_nx == ST_HIGH) begin
                shreg    <= {1'b1, shreg[PS2_FRAME_BITS-1:1]};
                bit_idx  <= bit_idx + 1'b1;
                ps2_data <= shreg[1];
            end else if (state_nx == ST_GAP) begin
                ps2_data <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: randomized scoreboard bench; a monitor decodes the PS/2 lines and checks each frame
// against a bit-level reference model. Build with PS2_TX_FIFO_EN to exercise the FIFO variant.
module tb_ps2_kbd_tx;
    import ps2_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int GAP     = 16;
    localparam int DEPTH   = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       tx_done;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: wire order, element i is the i-th bit on the line.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Monitor state
    int         cyc         = 0;
    int         bit_cnt     = 0;
    int         frames_seen = 0;
    int         done_cnt    = 0;
    int         hold_viol   = 0;
    int         rdy_viol    = 0;
    int         first_fall  = 0;
    int         last_fall   = 0;
    int         last_done   = -100000;
    bit         spacing_bad = 1'b0;
    bit         awaiting_done = 1'b0;
    logic [10:0] cap        = '0;
    logic [10:0] last_frame = '0;
    logic [7:0]  mon_exp;
    logic        prev_clk   = 1'b1;
    logic        prev_data  = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            bit_cnt       = 0;
            spacing_bad   = 1'b0;
            awaiting_done = 1'b0;
        end else begin
            if (!prev_clk && !ps2_clk && ps2_data !== prev_data) hold_viol++;
`ifndef PS2_TX_FIFO_EN
            if (in_ready !== !busy) rdy_viol++;
`endif
            if (prev_clk && !ps2_clk) begin
                if (bit_cnt == 0) first_fall = cyc;
                else if (cyc - last_fall != 2 * CLK_DIV) spacing_bad = 1'b1;
                last_fall = cyc;
                cap[bit_cnt] = ps2_data;
                bit_cnt++;
                if (bit_cnt == PS2_FRAME_BITS) begin
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        check("frame_bits", cap, model_frame(mon_exp));
                    end
                    check("fall_spacing", spacing_bad, 1'b0);
                    check("done_missing", awaiting_done, 1'b0);
                    check("gap_respected", (first_fall - last_done) >= (GAP + 1 + CLK_DIV), 1'b1);
                    last_frame    = cap;
                    frames_seen++;
                    bit_cnt       = 0;
                    spacing_bad   = 1'b0;
                    awaiting_done = 1'b1;
                end
            end
            if (tx_done) begin
                done_cnt++;
                check("done_after_frame", awaiting_done, 1'b1);
                check("done_timing", cyc - first_fall, 21 * CLK_DIV);
                awaiting_done = 1'b0;
                last_done     = cyc;
            end
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
    end

    // Called at a negedge; holds the byte until the DUT takes it.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            if (ok) exp_q.push_back(b);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("send_accept", ok, 1'b1);
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_seen < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("wait_frames", frames_seen >= n, 1'b1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", !busy && exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        int snap;
        int k;

        repeat (3) @(negedge clk);
        check("rst_ps2_clk", ps2_clk, 1'b1);
        check("rst_ps2_data", ps2_data, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // Start latency from idle
        in_valid = 1'b1;
        in_data  = 8'h1C;
        @(posedge clk);
        exp_q.push_back(8'h1C);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef PS2_TX_FIFO_EN
        check("lat_fifo_wait", busy, 1'b0);
        @(negedge clk);
`endif
        check("lat_busy", busy, 1'b1);
        check("lat_start_bit", ps2_data, 1'b0);
        check("lat_clk_high", ps2_clk, 1'b1);

        // Make/break replay 1C F0 1C with literal wire patterns
        send(PS2_BREAK);
        wait_frames(1);
        check("frame_1C", last_frame, 11'b10000111000);
        send(8'h1C);
        wait_frames(2);
        check("frame_F0", last_frame, 11'b11111100000);
        wait_frames(3);
        check("frame_1C_again", last_frame, 11'b10000111000);

        // Random back-to-back stream; in_valid stays high across frames
        for (int i = 0; i < 16; i++) send(8'($urandom));
        wait_idle();

`ifndef PS2_TX_FIFO_EN
        // Bytes offered mid-frame must be ignored
        send(8'($urandom));
        repeat (4) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        check("busy_ignore_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_idle();
`else
        // Nine pushes from idle: the first is popped at once, the ninth fills the FIFO
        for (int i = 0; i < 8; i++) send(8'($urandom));
        check("fifo_ready_at_7", in_ready, 1'b1);
        send(8'($urandom));
        check("fifo_full_at_8", in_ready, 1'b0);
        send(8'($urandom));
        wait_idle();
`endif

        // Reset in the middle of a frame
        send(8'($urandom));
`ifdef PS2_TX_FIFO_EN
        for (int i = 0; i < 3; i++) send(8'($urandom));
`endif
        k = 0;
        while (bit_cnt < 5 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_bit5", bit_cnt >= 5, 1'b1);
        snap = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ps2_clk", ps2_clk, 1'b1);
        check("midrst_ps2_data", ps2_data, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tx_done", tx_done, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt, snap);
        check("midrst_stays_idle", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);

        // Recovery after reset
        for (int i = 0; i < 3; i++) send(8'($urandom));
        wait_idle();

        check("data_hold_low", hold_viol, 0);
        check("ready_vs_busy", rdy_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 frame transmitter, the keyboard end of the PS/2 link. It accepts scan-code bytes over a valid/ready handshake and generates `ps2_clk` and `ps2_data` waveforms: start bit, 8 data bits LSB-first, odd parity, stop bit. It drives the host-side keyboard receiver in simulation and on the board, so make/break sequences such as `1C F0 1C` can be replayed without a physical keyboard.

## Interface
- `CLK_DIV`, 8, `clk` cycles per PS/2 clock half-period; must be ≥ 4.
- `GAP`, 16, idle `clk` cycles forced between frames; must be ≥ 1.
- `DEPTH`, 8, FIFO entries; power of two. Used only with `PS2_TX_FIFO_EN`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  `in_data` holds a byte to send
- `in_data`  in  8  scan-code byte
- `in_ready`  out  1  byte accepted on the edge where `in_valid & in_ready`
- `ps2_clk`  out  1  PS/2 clock; idles high
- `ps2_data`  out  1  PS/2 data; idles high
- `busy`  out  1  frame in progress, including the gap
- `tx_done`  out  1  one-cycle pulse after the stop bit's low phase

## Operation
- Frame shift register, 11 bits, sent bit 0 first: `{1'b1, ~^data, data[7:0], 1'b0}`.
  - Parity is odd: data plus parity bit always holds an odd number of ones.
- State machine:
  - `IDLE`: if a byte is available, load the shift register, clear `bit_idx` and `div_cnt`, go to `HIGH`.
  - `HIGH`: `ps2_clk`=1 and `ps2_data`=current bit. Lasts `CLK_DIV` cycles, then go to `LOW`.
  - `LOW`: `ps2_clk`=0 and `ps2_data` is held. Lasts `CLK_DIV` cycles.
    - If `bit_idx` < 10: increment `bit_idx`, go to `HIGH`.
    - If `bit_idx` = 10: pulse `tx_done`, go to `GAP`.
  - `GAP`: `ps2_clk`=1 and `ps2_data`=1. Lasts `GAP` cycles, then go to `IDLE`.
- `ps2_data` changes only on entry to `HIGH`, never while `ps2_clk` is low. The receiver samples on the falling edge.
- `div_cnt` width is `$clog2(CLK_DIV)`; it resets to 0 on every state change. `bit_idx` is 4 bits wide and never exceeds 10.
- `busy` = state ≠ `IDLE`.
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `tx_done`=0, state `IDLE`. `in_ready`=1 after reset.
- Reset asserted mid-frame: the frame is abandoned and both lines read 1 on the cycle after the reset edge. No `tx_done` is generated. All buffered bytes are discarded.

## Timing
- Frame length: 22·`CLK_DIV` cycles from `HIGH` entry to `GAP` entry, plus `GAP` cycles.
  - With defaults: 176 + 16 = 192 cycles per byte.
- Falling edges of `ps2_clk`: exactly 11 per frame, spaced 2·`CLK_DIV` cycles apart.
- `tx_done` is high for the single cycle in which state = `GAP` for the first time.
- Start latency is given in the Configuration section.

## Configuration
- `PS2_TX_FIFO_EN` defined:
  - A `DEPTH`-entry FIFO sits before the frame engine; `in_ready` = !full.
  - A push and a pop in the same cycle are both honoured.
  - When full, `in_ready`=0 even if a pop happens that cycle; there is no bypass.
  - `IDLE` pops when the FIFO is non-empty.
  - Latency: a byte accepted at edge N into an empty FIFO while `IDLE` gives `HIGH` (start bit on `ps2_data`) at cycle N+2.
  - Pointers are `$clog2(DEPTH)`+1 bits wide; wrap-around is correct across more than 2·`DEPTH` bytes.
- `PS2_TX_FIFO_EN` undefined:
  - No FIFO; `in_ready` = (state == `IDLE`).
  - Accept at edge N loads the shift register directly; `HIGH` starts at cycle N+1.
  - `in_valid` while not ready is ignored and the byte is not latched.

## Structure
- Package `ps2_pkg` holds:
  - the state enum `ps2_tx_state_t`;
  - the constants `PS2_FRAME_BITS`=11 and `PS2_BREAK`=8'hF0;
  - the function `ps2_frame(byte)`, which returns the 11-bit frame.
- Sub-module `ps2_tx_fifo` (push/pop/full/empty/rd_data), instantiated only under `PS2_TX_FIFO_EN`.

## Test plan
- Send 8'h1C with defaults → `ps2_data` at the 11 falling edges reads 0,0,0,1,1,1,0,0,0,0,1. `tx_done` fires 176 cycles after `HIGH` entry.
- Send 8'hF0 → parity bit 1; frame 0,0,0,0,0,1,1,1,1,1,1.
- Send `1C F0 1C` into the host-side keyboard receiver → `ready` pulses for the first `1C` and stays low for the `F0` and the final `1C`. Seven-segment outputs blank after each deassertion.
- With FIFO: push 9 bytes back-to-back from idle → `in_ready` drops after 8 bytes are buffered. All 9 bytes are sent in order, separated by `GAP`.
- Without FIFO: hold `in_valid` high during a frame → exactly one byte is accepted per `IDLE` visit.
- Assert `rst` at bit 5 of a frame → both lines read 1 on the next cycle, `busy`=0, no `tx_done`. After `rst` deasserts, the FIFO is empty.
